// File: rtl/pixel_vec_pkg.sv
// pixel_vec_pkg: shared state encoding and constants for the pixel vector loader
package pixel_vec_pkg;
    localparam int LANES           = 4;
    localparam int LANE_STRIDE_DEF = 32;
    localparam int VEC_STRIDE_DEF  = 1;
    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUF,
        FETCH,
        DRAIN,
        WRITE,
        FIN
    } loader_state_t;
endpackage

// File: rtl/pingpong_tracker.sv
// pingpong_tracker: full flags and read/write slot pointers for the two-slot vector bank
module pingpong_tracker
    import pixel_vec_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic commit,
    input  logic rd_release,
    output logic slot_free,
    output logic wr_pos,
    output logic rd_pos,
    output logic rd_valid
);
    logic [1:0] r_full;
    logic       r_wr_pos;
    logic       r_rd_pos;
    logic       w_rel;
    logic [1:0] w_set;
    logic [1:0] w_clr;
    assign w_rel = rd_release && r_full[r_rd_pos];
    assign w_set = commit ? (r_wr_pos ? 2'b10 : 2'b01) : 2'b00;
    assign w_clr = w_rel ? (r_rd_pos ? 2'b10 : 2'b01) : 2'b00;
    // set the written slot and clear the released slot; they never coincide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full   <= 2'b00;
            r_wr_pos <= 1'b0;
            r_rd_pos <= 1'b0;
        end else begin
            r_full   <= (r_full & ~w_clr) | w_set;
            r_wr_pos <= r_wr_pos ^ commit;
            r_rd_pos <= r_rd_pos ^ w_rel;
        end
    end
    assign slot_free = !r_full[r_wr_pos];
    assign wr_pos    = r_wr_pos;
    assign rd_pos    = r_rd_pos;
    assign rd_valid  = r_full[r_rd_pos];
endmodule

// File: rtl/pixel_vector_loader.sv
// pixel_vector_loader: fetches four-lane pixel vectors from memory into a ping-pong bank
module pixel_vector_loader
    import pixel_vec_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 16,
    parameter int LANE_STRIDE = LANE_STRIDE_DEF,
    parameter int VEC_STRIDE  = VEC_STRIDE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  vec_count,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              we,
    output logic              wr_pos,
    output logic [31:0]       wd1,
    output logic [31:0]       wd2,
    output logic [31:0]       wd3,
    output logic [31:0]       wd4,
    output logic              rd_pos,
    output logic              rd_valid,
    input  logic              rd_release
);
    loader_state_t           r_state;
    logic [ADDR_W-1:0]       r_vaddr;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [CNT_W-1:0]        r_cnt;
    logic [1:0]              r_lane;
    logic [LANES-1:0][31:0]  r_wd;
    logic                    r_mem_rd;
    logic                    r_we;
    logic                    r_done;
    logic                    r_busy;
    logic                    w_slot_free;
    logic                    w_commit;
    assign w_commit = (r_state == WRITE);
    pingpong_tracker u_tracker (
        .clk        (clk),
        .rst        (rst),
        .commit     (w_commit),
        .rd_release (rd_release),
        .slot_free  (w_slot_free),
        .wr_pos     (wr_pos),
        .rd_pos     (rd_pos),
        .rd_valid   (rd_valid)
    );
    // load sequencer: address generation, lane capture and registered strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_vaddr    <= '0;
            r_mem_addr <= '0;
            r_cnt      <= '0;
            r_lane     <= '0;
            r_wd       <= '0;
            r_mem_rd   <= 1'b0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && vec_count != '0) begin
                        r_vaddr <= base_addr;
                        r_cnt   <= vec_count;
                        r_busy  <= 1'b1;
                        r_state <= WAIT_BUF;
                    end else if (start) begin
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end
                end
                WAIT_BUF: begin
                    if (w_slot_free) begin
                        r_lane     <= 2'd0;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_vaddr;
                        r_state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (r_lane != 2'd0)
                        r_wd[r_lane - 2'd1] <= mem_rdata;
                    r_lane     <= r_lane + 2'd1;
                    r_mem_rd   <= (r_lane != 2'd3);
                    r_mem_addr <= (r_lane == 2'd3) ? '0 : r_mem_addr + ADDR_W'(LANE_STRIDE);
                    r_state    <= (r_lane == 2'd3) ? DRAIN : FETCH;
                end
                DRAIN: begin
                    r_wd[LANES-1] <= mem_rdata;
                    r_we          <= 1'b1;
                    r_state       <= WRITE;
                end
                WRITE: begin
                    r_we    <= 1'b0;
                    r_vaddr <= r_vaddr + ADDR_W'(VEC_STRIDE);
                    r_cnt   <= r_cnt - CNT_W'(1);
                    r_busy  <= (r_cnt != CNT_W'(1));
                    r_done  <= (r_cnt == CNT_W'(1));
                    r_state <= (r_cnt == CNT_W'(1)) ? FIN : WAIT_BUF;
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign busy     = r_busy;
    assign done     = r_done;
    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign we       = r_we;
    assign wd1      = r_wd[0];
    assign wd2      = r_wd[1];
    assign wd3      = r_wd[2];
    assign wd4      = r_wd[3];
endmodule

// File: doc/pixel_vector_loader.md
# pixel_vector_loader

Fetches pixel vectors from data memory and fills the two-slot, four-lane pixel vector bank in the decode stage. It is the write-side partner of that bank. For each vector it reads four words from memory, one per lane, then writes them in a single `we` cycle to the slot selected by `wr_pos`. It tracks which ping-pong slots are full so the vector datapath knows which slot to read (`rd_pos`) and when that slot's data is valid. It never overwrites a slot that has not been released.

## Interface
Parameters:
- `ADDR_W`, default 32: memory address width.
- `CNT_W`, default 16: width of the vector count.
- `LANE_STRIDE`, default 32: word-address offset between lanes of one vector. It matches the bank's lane placement at 0/32/64/96.
- `VEC_STRIDE`, default 1: word-address step between consecutive vectors.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle request to begin a load. Sampled only in IDLE.
- `base_addr` in ADDR_W: address of lane 0 of vector 0. Latched on an accepted `start`.
- `vec_count` in CNT_W: number of vectors to load. Latched on an accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the load is complete.
- `mem_rd` out 1: memory read strobe.
- `mem_addr` out ADDR_W: memory read address.
- `mem_rdata` in 32: read data, valid the cycle after `mem_rd`.
- `we` out 1: bank write enable.
- `wr_pos` out 1: bank slot being written.
- `wd1`, `wd2`, `wd3`, `wd4` out 32 each: lane data for lanes 0 to 3.
- `rd_pos` out 1: bank slot the consumer must read.
- `rd_valid` out 1: high when slot `rd_pos` is full.
- `rd_release` in 1: consumer has finished with slot `rd_pos`.

## Operation
- State machine states: IDLE, WAIT_BUF, FETCH, DRAIN, WRITE, FIN.
- IDLE:
  - On `start` with `vec_count` nonzero: latch the inputs, set `vaddr` = `base_addr` and remaining count = `vec_count`, go to WAIT_BUF.
  - On `start` with `vec_count` = 0: go to FIN. No memory reads are issued.
- WAIT_BUF: stay while `full[wr_pos]` is 1; otherwise go to FETCH with lane counter = 0.
- FETCH (4 cycles, lane l = 0 to 3):
  - `mem_rd` = 1 and `mem_addr` = `vaddr` + l×`LANE_STRIDE`.
  - From the second FETCH cycle, `mem_rdata` is captured into lane register l−1.
  - After l = 3, go to DRAIN.
- DRAIN: capture `mem_rdata` into lane 3; go to WRITE.
- WRITE:
  - `we` = 1 for exactly this cycle, with `wd1`–`wd4` stable and `wr_pos` equal to the target slot.
  - Next edge: set `full[wr_pos]`, toggle `wr_pos`, add `VEC_STRIDE` to `vaddr`, decrement the count.
  - Go to FIN if the count reaches 0; otherwise go to WAIT_BUF.
- FIN: `done` = 1 for one cycle; go to IDLE.
- `start` is ignored in any state other than IDLE.
- Release side, independent of the state machine:
  - `rd_valid` = `full[rd_pos]`.
  - `rd_release` while `rd_valid` = 1: clear `full[rd_pos]` and toggle `rd_pos`.
  - `rd_release` while `rd_valid` = 0: ignored.
- Simultaneous WRITE and release: both take effect in the same cycle. They always target different slots, because WRITE requires its slot empty and release requires its slot full.
- `wr_pos`, `rd_pos` and the full flags persist across loads; a new `start` does not reset them.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.

## Timing
- Reset values: all outputs are 0 and state is IDLE. This covers `busy`, `done`, `mem_rd`, `mem_addr`, `we`, `wr_pos`, `wd1`–`wd4`, `rd_pos` and `rd_valid`. Both full flags are 0.
- Reset asserted mid-load: immediate abort, with all state returning to the reset values. The bank keeps whatever contents it has, but those contents are logically invalid.
- Each vector with a free slot takes 6 cycles: 1 WAIT_BUF, 4 FETCH, 1 DRAIN. `we` is asserted in a seventh cycle (WRITE).
- Full load of N vectors with slots always free:
  - `start` in cycle 0; `we` first asserted in cycle 7.
  - `done` in cycle 7N+1 (N ≥ 1).
- `done` and `busy` are never high in the same cycle.

## Structure
- Package `pixel_vec_pkg`: the state enum `loader_state_t`, the constant `LANES` = 4, and the default stride constants.
- Sub-module `pingpong_tracker` holds `full[1:0]`, `wr_pos` and `rd_pos`.
  - Inputs: `commit` (asserted in WRITE) and `rd_release`.
  - Outputs: `slot_free`, `wr_pos`, `rd_pos`, `rd_valid`.
- The top level contains the state machine, address generator and lane capture registers.

## Test plan
- Single vector, model memory holds mem[a] = a:
  - Stimulus: `base_addr` = 0x100, `vec_count` = 1.
  - Response: reads at 0x100, 0x120, 0x140, 0x160; one `we` with `wr_pos` = 0 and `wd1`–`wd4` = 0x100/0x120/0x140/0x160.
  - Then `rd_valid` = 1 with `rd_pos` = 0, `done` in cycle 8, and `wr_pos` = 1.
- Backpressure:
  - Stimulus: `vec_count` = 3, no `rd_release`.
  - Response: two writes (slots 0 then 1), then the block stays in WAIT_BUF with `busy` = 1.
  - Then one `rd_release`: `rd_pos` becomes 1, and the third write goes to slot 0.
- Simultaneous release and write: assert `rd_release` in the same cycle as a WRITE to the other slot. Both flags update correctly: released slot clear, written slot set.
- Zero count:
  - Stimulus: `start` with `vec_count` = 0.
  - Response: `mem_rd` never asserted, `done` pulses in cycle 1, `busy` stays 0.
- Robustness:
  - `start` pulsed during FETCH is ignored.
  - `rst` pulled low during FETCH: all outputs are 0 in the same cycle, and a following load starts again at slot 0.
  - `base_addr` = 0xFFFFFFF0 wraps lane addresses, giving lanes 0x10/0x30/0x50 after the first.
